// File: rtl/digota_pkg.sv
// Shared types and default constants for the digital-OTA comparator back end.
package digota_pkg;

  localparam int unsigned DIGOTA_OSR_LOG2      = 6;
  localparam int unsigned DIGOTA_SYNC_STAGES   = 2;
  localparam int unsigned DIGOTA_SETTLE_CYCLES = 4;

  // Ones-count of a full window is 2^OSR_LOG2, one bit wider than the window index
  localparam int unsigned DIGOTA_SAMPLE_W = DIGOTA_OSR_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2
  } state_t;

endpackage

// File: rtl/digota_sd_decimator_if.sv
// Decimated-sample valid/ready port between the decimator and its consumer.
interface digota_sd_decimator_if #(
  parameter int unsigned SAMPLE_W = digota_pkg::DIGOTA_SAMPLE_W
);
  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample, output sample_valid, input  sample_ready);
  modport slave  (input  sample, input  sample_valid, output sample_ready);
endinterface

// File: rtl/digota_sync.sv
// Multi-flop single-bit synchroniser with synchronous reset to 0.
module digota_sync #(
  parameter int unsigned STAGES = digota_pkg::DIGOTA_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/digota_sd_decimator.sv
// Synchronises the comparator decision, feeds it back to the DAC and boxcar-decimates
// it into ones-counts over 2^OSR_LOG2-cycle windows presented on a valid/ready port.
module digota_sd_decimator
  import digota_pkg::*;
#(
  parameter int unsigned OSR_LOG2      = DIGOTA_OSR_LOG2,
  parameter int unsigned SYNC_STAGES   = DIGOTA_SYNC_STAGES,
  parameter int unsigned SETTLE_CYCLES = DIGOTA_SETTLE_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          cmp_in,
  output logic                          fb_out,
  output logic                          overrun,
  output logic                          busy,
  digota_sd_decimator_if.master         out_if
);

  localparam int unsigned SW  = OSR_LOG2 + 1;
  localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [OSR_LOG2-1:0] WIN_LAST    = '1;
  localparam logic [SCW-1:0]      SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

  state_t               state, state_n;
  logic                 s_bit;
  logic [SCW-1:0]       settle_cnt, settle_cnt_n;
  logic [OSR_LOG2-1:0]  win_cnt, win_cnt_n;
  logic [SW-1:0]        acc, acc_n;
  logic [SW-1:0]        sample_n;
  logic                 valid_n, overrun_n, window_done;

  digota_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (cmp_in),
    .q   (s_bit)
  );

  assign fb_out = s_bit;

  // State register; busy is registered alongside the state it reflects
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (en) state_n = ST_SETTLE;
      ST_SETTLE: begin
        if (!en)                            state_n = ST_IDLE;
        else if (settle_cnt == SETTLE_LAST) state_n = ST_ACCUM;
      end
      ST_ACCUM:  if (!en) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Datapath next values; counters default to 0 so IDLE and window restarts clear them
  always_comb begin
    settle_cnt_n = '0;
    win_cnt_n    = '0;
    acc_n        = '0;
    window_done  = 1'b0;
    case (state)
      ST_SETTLE: begin
        if (en && settle_cnt != SETTLE_LAST) settle_cnt_n = settle_cnt + SCW'(1);
      end
      ST_ACCUM: begin
        if (en) begin
          if (win_cnt == WIN_LAST) begin
            window_done = 1'b1;
          end else begin
            win_cnt_n = win_cnt + OSR_LOG2'(1);
            acc_n     = acc + SW'(s_bit);
          end
        end
      end
      default: ;
    endcase

    sample_n  = out_if.sample;
    valid_n   = out_if.sample_valid;
    overrun_n = overrun;
    // A completing window wins over a transfer; overwriting an unconsumed result is an overrun
    if (window_done) begin
      sample_n = acc + SW'(s_bit);
      valid_n  = 1'b1;
      if (out_if.sample_valid && !out_if.sample_ready) overrun_n = 1'b1;
    end else if (out_if.sample_valid && out_if.sample_ready) begin
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt          <= '0;
      win_cnt             <= '0;
      acc                 <= '0;
      out_if.sample       <= '0;
      out_if.sample_valid <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      settle_cnt          <= settle_cnt_n;
      win_cnt             <= win_cnt_n;
      acc                 <= acc_n;
      out_if.sample       <= sample_n;
      out_if.sample_valid <= valid_n;
      overrun             <= overrun_n;
    end
  end

endmodule

// File: doc/digota_sd_decimator.md
Name: digota_sd_decimator

Overview:
- Downstream stage of the digital OTA comparator; consumes its 1-bit asynchronous decision output.
- Synchronises the decision and returns it as the registered 1-bit feedback for the loop DAC.
- Counts ones over a fixed oversampling window (first-order boxcar decimation) and presents each window's result on a valid/ready output port.

Parameters:
- OSR_LOG2, 6, log2 of window length; window = 2^OSR_LOG2 clk cycles (64 by default).
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser; minimum 2.
- SETTLE_CYCLES, 4, synchronised samples discarded after enable before the first window; minimum 1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable; level-sensitive.
- cmp_in  input  1  comparator decision; asynchronous to clk.
- fb_out  output  1  synchronised decision for the feedback DAC.
- sample  output  OSR_LOG2+1  ones-count of the last completed window.
- sample_valid  output  1  sample holds an unconsumed result.
- sample_ready  input  1  consumer accepts sample when high with sample_valid.
- overrun  output  1  sticky flag: a result was overwritten before it was consumed.
- busy  output  1  high in SETTLE or ACCUM.

Behaviour:
- Reset, checked at the clock edge:
  - All outputs go to 0: fb_out, sample, sample_valid, overrun, busy.
  - Synchroniser chain, accumulator and counters clear; FSM goes to IDLE.
  - Reset applies mid-window and mid-handshake; any pending result is lost.
- Synchroniser: cmp_in passes through SYNC_STAGES flops; the last flop is s_bit. fb_out = s_bit and runs in all states, including IDLE.
- FSM states: IDLE, SETTLE, ACCUM.
- IDLE:
  - Accumulator and counters held at 0.
  - en=1 moves to SETTLE on the next edge.
- SETTLE:
  - Counts SETTLE_CYCLES cycles; s_bit is ignored.
  - Then moves to ACCUM with accumulator=0 and window counter=0.
- ACCUM:
  - Each cycle adds s_bit to the accumulator and increments the window counter.
  - On the cycle the counter reaches 2^OSR_LOG2-1:
    - sample is loaded with the accumulator plus the current s_bit.
    - The accumulator restarts at 0 on the next cycle, so there is no gap between windows.
  - sample_valid rises on the edge that loads sample.
- en=0 in SETTLE or ACCUM:
  - Next state is IDLE; the partial window is discarded and no result is produced.
  - A held sample and sample_valid remain until consumed.
  - Re-enabling always passes through SETTLE again.
- Width: the maximum count is 2^OSR_LOG2, which needs OSR_LOG2+1 bits. No saturation logic is required.
- Handshake:
  - A transfer occurs on any edge with sample_valid=1 and sample_ready=1; sample_valid then clears.
  - sample stays stable while sample_valid=1 and no new window completes.
  - sample_ready is ignored when sample_valid=0.
- Window completes while sample_valid=1 and sample_ready=0: sample is overwritten, sample_valid stays 1, overrun sets.
- Window completes in the same cycle as a transfer: the old value is consumed, the new value loads, sample_valid stays 1, overrun is unchanged.
- overrun: sticky; cleared only by rst.
- busy = (state != IDLE), registered together with the state.
- Latency:
  - A cmp_in edge is counted SYNC_STAGES cycles later.
  - sample_valid rises 1 cycle after the last counted cycle of a window.
  - From en rising to first sample_valid: 1 + SETTLE_CYCLES + 2^OSR_LOG2 cycles.

Decomposition:
- Package digota_pkg:
  - FSM state enum (IDLE/SETTLE/ACCUM).
  - Default constants DIGOTA_OSR_LOG2=6, DIGOTA_SYNC_STAGES=2, DIGOTA_SETTLE_CYCLES=4.
  - Width helper constant for the sample width.
- Sub-module digota_sync: parameterised bit synchroniser with synchronous reset to 0.
  - Instantiated once here.
  - Reusable by other blocks in the same design.

Test Plan:
- cmp_in=1 constant, en=1, sample_ready=1 → sample=64, one-cycle sample_valid pulse every 64 cycles; first pulse 69 cycles after en rises; fb_out=1 after 2 cycles.
- cmp_in=0 constant → sample=0 each window; then cmp_in toggling every cycle → sample=32 for every fully toggling window.
- sample_ready=0 across two completed windows (first with cmp_in=1, second with cmp_in=0) → sample_valid stays 1, sample=0, overrun=1 and stays 1 after a later transfer until rst.
- sample_ready=1 on exactly the window-completion edge while a result is pending → old value consumed, new value presented, sample_valid stays 1, overrun=0.
- en drops at window cycle 30 → FSM returns to IDLE, no sample_valid; en re-asserted → first result 69 cycles later and equals the full 64-cycle count.
- rst for 1 cycle mid-window with sample_valid=1 → all outputs 0 the next cycle, FSM in IDLE; en still high → SETTLE entered the cycle after rst releases.
